dot_acc: RTL and testbench
==========================

Name: dot_acc

Overview:
- Downstream consumer of the 32x32 Vedic multiplier in the matrix multiplier datapath.
- Accumulates a stream of unsigned 64-bit products into one dot-product sum, i.e. one output matrix element, per VEC_LEN products.
- Presents each completed sum through a 1-deep valid/ready output buffer to the result writer.
- The multiplier has no backpressure, so the block flags any sum lost to a full output buffer.

Parameters:
- VEC_LEN, 4: products per dot product (>= 2).
- PROD_W, 64: product width, matching the multiplier result.
- CNT_W, $clog2(VEC_LEN+1): localparam; element-counter width.
- ACC_W, PROD_W+$clog2(VEC_LEN): localparam; accumulator width, chosen so the sum never overflows.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- prod  in  PROD_W  product from the multiplier result
- prod_valid  in  1  multiplier done; exactly one product per high cycle
- clear  in  1  synchronous discard of the partial sum
- flush  in  1  emit the partial sum early (honoured only with DOT_ACC_FLUSH_EN)
- out_data  out  ACC_W  completed dot product
- out_count  out  CNT_W  number of products in out_data
- out_valid  out  1  output buffer holds data
- out_ready  in  1  consumer accepts when out_valid & out_ready
- ovf_err  out  1  sticky: a completed sum was dropped
- busy  out  1  partial sum in progress (elem_cnt != 0)

Behaviour:
- Reset: acc=0, elem_cnt=0, out_data=0, out_count=0, out_valid=0, ovf_err=0, busy=0. Asserting reset mid-vector discards everything.
- Per edge with prod_valid=1: sum_nxt = acc + zero-extended prod (combinational, ACC_W bits).
  - If elem_cnt == VEC_LEN-1 (last element): emit sum_nxt with count VEC_LEN; acc←0, elem_cnt←0.
  - Otherwise: acc←sum_nxt, elem_cnt←elem_cnt+1.
- Emit:
  - If the buffer is free (out_valid=0) or drains in the same cycle (out_valid & out_ready): load out_data/out_count and set out_valid=1 next cycle.
  - Otherwise: drop the sum and set ovf_err=1. The accumulator still restarts.
- Latency: last product at edge t → out_valid high after edge t, carrying the sum that includes that product.
- Output handshake:
  - out_data/out_count hold stable while out_valid & !out_ready.
  - out_valid clears after an accepting edge unless a new emit occurs in the same cycle (back-to-back throughput of one sum per cycle is supported).
- clear: highest priority after reset. acc←0, elem_cnt←0. A prod_valid in the same cycle is discarded. The output buffer and ovf_err are unaffected.
- ovf_err: cleared only by reset.
- Arithmetic: unsigned. No wrap is possible for VEC_LEN products of at most 2^PROD_W-1.

Optional Feature:
- Macro DOT_ACC_FLUSH_EN.
- Defined: flush=1 emits the partial sum early.
  - The emitted sum includes a prod_valid product arriving in the same cycle.
  - out_count = elem_cnt, +1 if prod_valid.
  - acc and elem_cnt reset to 0.
  - Emit rules and overflow rules are the same as a normal completion.
  - If the sum is empty (elem_cnt=0 and no prod_valid): no emit.
  - If prod_valid is on the last element: a single normal emit.
  - clear in the same cycle wins: no emit.
- Undefined: the flush port exists but is ignored, and no flush logic is synthesised.

Decomposition:
- Shared package (matmul_pkg): PROD_W=64, default VEC_LEN, and the ACC_W computation function.
- One sub-module, dot_acc_out_buf: parameterised ACC_W+CNT_W 1-deep valid/ready holding register. It reports "can_load" and raises the drop indication.
- Accumulator, counter and control stay in dot_acc.

Test Plan:
- VEC_LEN=4; products 1, 2, 3, 4 on consecutive cycles, out_ready=1 → one out_valid pulse the cycle after the 4th product; out_data=10, out_count=4; busy low afterwards.
- Four products of 0xFFFF_FFFF_FFFF_FFFF → out_data=0x3_FFFF_FFFF_FFFF_FFFC (66-bit), no wrap.
- out_ready=0; two full vectors (sums 10 and 26) → out_data holds 10 and ovf_err=1. Then assert out_ready → 10 accepted, no 26, ovf_err stays 1.
- Two products 5, 7, then clear with a simultaneous product 9, then 1, 1, 1, 1 → only one output, out_data=4.
- Sum 10 held (out_ready=0); next vector completes in the same cycle out_ready rises → 10 accepted, then the new sum presented the next cycle, no ovf_err.
- DOT_ACC_FLUSH_EN: products 3, 4, then flush with product 5 → out_data=12, out_count=3. A flush on an idle block produces no output. The same stimulus without the macro produces no output until the 4th product.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared matrix-multiplier constants and width helpers.
// Imported by the dot-product accumulator and its output buffer.
package matmul_pkg;

  localparam int MM_PROD_W  = 64;
  localparam int MM_VEC_LEN = 4;

  // Accumulator wide enough that vec_len full-scale
  // products can never wrap.
  function automatic int acc_width(
    input int prod_w,
    input int vec_len
  );
    return prod_w + $clog2(vec_len);
  endfunction

  function automatic int cnt_width(
    input int vec_len
  );
    return $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/dot_acc_out_buf.sv
// 1-deep valid/ready holding register for completed sums.
// Ports: clk, reset, load_i/data_i (offer), ready_i,
//   valid_o/data_o (held entry), can_load_o, drop_o.
module dot_acc_out_buf
  import matmul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         can_load_o,
  output logic         drop_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Free now, or the held entry leaves this cycle.
  assign can_load_o = !valid_q || ready_i;
  assign drop_o     = load_i && !can_load_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i && can_load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dot_acc.sv
// Accumulates VEC_LEN products into one dot-product sum.
// Ports: clk, reset, prod/prod_valid, clear, flush,
//   out_data/out_count/out_valid/out_ready, ovf_err, busy.
// Optional early emit on flush: define DOT_ACC_FLUSH_EN.
module dot_acc
  import matmul_pkg::*;
#(
  parameter  int VEC_LEN = MM_VEC_LEN,
  parameter  int PROD_W  = MM_PROD_W,
  localparam int CNT_W   = cnt_width(VEC_LEN),
  localparam int ACC_W   = acc_width(PROD_W, VEC_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              clear,
  input  logic              flush,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf_err,
  output logic              busy
);

  localparam int BW = ACC_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(VEC_LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum_nxt;
  logic             last;
  logic             emit;
  logic [ACC_W-1:0] emit_sum;
  logic [CNT_W-1:0] emit_cnt;
  logic             drop;
  logic             can_load;
  logic [BW-1:0]    buf_q;

  assign sum_nxt = acc_q + ACC_W'(prod);
  assign last    = prod_valid && (cnt_q == LAST);

`ifdef DOT_ACC_FLUSH_EN
  logic fl_go;

  // Empty partials are never emitted.
  assign fl_go = flush && (prod_valid || cnt_q != '0);
  assign emit  = !clear && (last || fl_go);
  assign emit_sum = prod_valid ? sum_nxt : acc_q;
  // On the last element this is VEC_LEN.
  assign emit_cnt = cnt_q + CNT_W'(prod_valid);
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign emit     = !clear && last;
  assign emit_sum = sum_nxt;
  assign emit_cnt = CNT_W'(VEC_LEN);
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | drop;
    if (clear || emit) begin
      // Restart even when the sum was dropped.
      acc_d = '0;
      cnt_d = '0;
    end else if (prod_valid) begin
      acc_d = sum_nxt;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  dot_acc_out_buf #(
    .W (BW)
  ) u_obuf (
    .clk        (clk),
    .reset      (reset),
    .load_i     (emit),
    .data_i     ({emit_cnt, emit_sum}),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (buf_q),
    .can_load_o (can_load),
    .drop_o     (drop)
  );

  logic unused_can_load;

  assign unused_can_load = can_load;
  assign out_data  = buf_q[ACC_W-1:0];
  assign out_count = buf_q[BW-1:ACC_W];
  assign ovf_err   = ovf_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_dot_acc.sv
// Randomized and directed bench for dot_acc.
// Compares against a queue-based dot-product model.
module tb_dot_acc;
  import matmul_pkg::*;

  localparam int VL = 4;
  localparam int PW = 64;
  localparam int CW = cnt_width(VL);
  localparam int AW = acc_width(PW, VL);

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] prod;
  logic          prod_valid;
  logic          clear;
  logic          flush;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;
  logic          ovf_err;
  logic          busy;

  dot_acc #(
    .VEC_LEN (VL),
    .PROD_W  (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prod       (prod),
    .prod_valid (prod_valid),
    .clear      (clear),
    .flush      (flush),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_err    (ovf_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_flush = 0;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Model: products of the open vector, plus the
  // single-entry output slot and the sticky error.
  logic [PW-1:0] elems[$];
  bit            m_v;
  logic [AW-1:0] m_d;
  logic [CW-1:0] m_c;
  bit            m_ovf;

  task automatic model_reset();
    elems.delete();
    m_v   = 0;
    m_d   = '0;
    m_c   = '0;
    m_ovf = 0;
  endtask

  task automatic model_edge(
    input bit          pv,
    input logic [PW-1:0] p,
    input bit          clr,
    input bit          fl,
    input bit          rdy
  );
    bit            done;
    logic [AW-1:0] sum;
    done = 0;
    n_flush += int'(fl);
    if (clr) begin
      elems.delete();
    end else begin
      if (pv) elems.push_back(p);
      if (elems.size() == VL) done = 1;
`ifdef DOT_ACC_FLUSH_EN
      if (fl && elems.size() != 0) done = 1;
`endif
    end
    if (m_v && rdy) m_v = 0;
    if (done) begin
      sum = '0;
      foreach (elems[i]) sum = sum + AW'(elems[i]);
      if (!m_v) begin
        m_v = 1;
        m_d = sum;
        m_c = CW'(elems.size());
      end else begin
        m_ovf = 1;
      end
      elems.delete();
    end
  endtask

  task automatic compare_all();
    check("valid", 128'(out_valid), 128'(m_v));
    if (m_v) begin
      check("data", 128'(out_data), 128'(m_d));
      check("count", 128'(out_count), 128'(m_c));
    end
    check("ovf", 128'(ovf_err), 128'(m_ovf));
    check("busy", 128'(busy),
          128'(elems.size() != 0));
  endtask

  task automatic step(
    input bit          pv,
    input logic [PW-1:0] p,
    input bit          clr,
    input bit          fl,
    input bit          rdy
  );
    prod_valid = pv;
    prod       = p;
    clear      = clr;
    flush      = fl;
    out_ready  = rdy;
    @(posedge clk);
    model_edge(pv, p, clr, fl, rdy);
    #1;
    compare_all();
  endtask

  task automatic prd(input logic [PW-1:0] p,
                     input bit rdy);
    step(1, p, 0, 0, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(0, '0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    reset      = 1;
    prod_valid = 0;
    prod       = '0;
    clear      = 0;
    flush      = 0;
    out_ready  = 0;
    #1;
    model_reset();
    compare_all();
    check("rst_data", 128'(out_data), 128'(0));
    check("rst_count", 128'(out_count), 128'(0));
    @(posedge clk);
    #1;
    reset = 0;
    compare_all();
  endtask

  logic [PW-1:0] ones;
  logic [PW-1:0] rp;

  initial begin
    ones = '1;
    do_reset();

    // 1+2+3+4
    for (int i = 1; i <= 4; i++) prd(PW'(i), 1);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_data", 128'(out_data), 128'(10));
    check("t1_count", 128'(out_count), 128'(4));
    check("t1_busy", 128'(busy), 128'(0));
    idle(1);
    check("t1_pulse", 128'(out_valid), 128'(0));

    // Full-scale products must not wrap.
    for (int i = 0; i < 4; i++) prd(ones, 1);
    check("t2_data", 128'(out_data),
          128'(66'h3_FFFF_FFFF_FFFF_FFFC));
    idle(1);

    // Overflow while the buffer is held.
    do_reset();
    for (int i = 1; i <= 8; i++) prd(PW'(i), 0);
    check("t3_data", 128'(out_data), 128'(10));
    check("t3_ovf", 128'(ovf_err), 128'(1));
    idle(1);
    check("t3_drain", 128'(out_valid), 128'(0));
    idle(1);
    check("t3_ovf2", 128'(ovf_err), 128'(1));

    // clear discards partial and coincident product.
    do_reset();
    prd(5, 1);
    prd(7, 1);
    step(1, 9, 1, 0, 1);
    check("t4_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 4; i++) begin
      check("t4_none", 128'(out_valid), 128'(0));
      prd(1, 1);
    end
    check("t4_data", 128'(out_data), 128'(4));
    idle(1);

    // Drain and load on the same edge.
    for (int i = 1; i <= 4; i++) prd(PW'(i), 0);
    for (int i = 5; i <= 7; i++) prd(PW'(i), 0);
    prd(8, 1);
    check("t5_data", 128'(out_data), 128'(26));
    check("t5_valid", 128'(out_valid), 128'(1));
    check("t5_ovf", 128'(ovf_err), 128'(0));
    idle(1);

    // Early flush (or its absence).
    do_reset();
    step(0, '0, 0, 1, 1);
    check("t6_idle", 128'(out_valid), 128'(0));
    prd(3, 1);
    prd(4, 1);
    step(1, 5, 0, 1, 1);
`ifdef DOT_ACC_FLUSH_EN
    check("t6_valid", 128'(out_valid), 128'(1));
    check("t6_data", 128'(out_data), 128'(12));
    check("t6_count", 128'(out_count), 128'(3));
`else
    check("t6_valid", 128'(out_valid), 128'(0));
    prd(6, 1);
    check("t6_data", 128'(out_data), 128'(18));
    check("t6_count", 128'(out_count), 128'(4));
`endif
    idle(1);

    // Reset in the middle of a vector.
    prd(2, 1);
    prd(2, 1);
    do_reset();
    for (int i = 0; i < 4; i++) prd(1, 1);
    check("t7_data", 128'(out_data), 128'(4));
    idle(1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rp = ones;
      else rp = {$urandom, $urandom};
      step($urandom_range(0, 9) < 7, rp,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6);
      if (i == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
